// File: rtl/cordic_vectoring_if.sv
// cordic_vectoring_if
// Handshake bundle for the CORDIC vectoring engine.
//   in_valid/in_ready  : input vector handshake, carries x_in/y_in (signed Q.8)
//   out_valid/out_ready: result handshake, carries mag_out (Q.8) and
//                        angle_out (degrees x 256)
// The master modport is the side that supplies vectors and consumes results;
// the slave modport is the engine itself.
interface cordic_vectoring_if #(
    parameter int W = 24
);
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] x_in;
    logic signed [W-1:0] y_in;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] mag_out;
    logic signed [W-1:0] angle_out;

    modport master (
        output in_valid, x_in, y_in, out_ready,
        input  in_ready, out_valid, mag_out, angle_out
    );

    modport slave (
        input  in_valid, x_in, y_in, out_ready,
        output in_ready, out_valid, mag_out, angle_out
    );
endinterface

// File: rtl/cordic_vectoring.sv
// cordic_vectoring
// Iterative CORDIC engine in vectoring mode: converts a Cartesian vector
// (x, y) in Q.8 into its magnitude (Q.8, gain-compensated) and its angle
// atan2(y, x) in degrees x 256. One micro-rotation per clock; one vector in
// flight at a time. The angle format and arctangent table are shared with the
// rotation-mode sin/cos generator so angle_out can be fed straight back into it.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-low reset; aborts any computation in flight
//   bus  : slave side of cordic_vectoring_if (in/out valid-ready handshakes)
module cordic_vectoring #(
    parameter int W    = 24,
    parameter int ITER = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    cordic_vectoring_if.slave     bus
);

    localparam int XW = W + 2;   // x/y headroom for CORDIC gain and pre-rotation
    localparam int PW = W + 12;  // gain-compensation product width

    localparam logic [3:0]           ITER_LAST = 4'(ITER - 1);
    localparam logic signed [PW-1:0] GAIN_K    = PW'(32'sd155);   // ~256/1.6468
    localparam logic signed [W-1:0]  ANG_P90   = W'(32'sd23040);
    localparam logic signed [W-1:0]  ANG_M90   = W'(-32'sd23040);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_SCALE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic signed [XW-1:0] x_q, x_d;
    logic signed [XW-1:0] y_q, y_d;
    logic signed [W-1:0]  z_q, z_d;
    logic [3:0]           i_q, i_d;
    logic                 zero_q, zero_d;
    logic                 out_valid_q, out_valid_d;
    logic signed [W-1:0]  mag_q, mag_d;
    logic signed [W-1:0]  angle_q, angle_d;

    logic signed [XW-1:0] x_ext_s;
    logic signed [XW-1:0] y_ext_s;
    logic signed [XW-1:0] x_sh_s;
    logic signed [XW-1:0] y_sh_s;

    // atan(2^-idx) in degrees x 256, identical to the sin/cos generator table
    function automatic logic signed [W-1:0] atan_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    atan_lut = W'(32'sd11520);
            4'd1:    atan_lut = W'(32'sd6801);
            4'd2:    atan_lut = W'(32'sd3593);
            4'd3:    atan_lut = W'(32'sd1824);
            4'd4:    atan_lut = W'(32'sd916);
            4'd5:    atan_lut = W'(32'sd458);
            4'd6:    atan_lut = W'(32'sd229);
            4'd7:    atan_lut = W'(32'sd115);
            4'd8:    atan_lut = W'(32'sd57);
            4'd9:    atan_lut = W'(32'sd29);
            4'd10:   atan_lut = W'(32'sd14);
            4'd11:   atan_lut = W'(32'sd7);
            4'd12:   atan_lut = W'(32'sd4);
            4'd13:   atan_lut = W'(32'sd2);
            4'd14:   atan_lut = W'(32'sd1);
            default: atan_lut = W'(32'sd0);
        endcase
    endfunction

    assign x_ext_s = {{2{bus.x_in[W-1]}}, bus.x_in};
    assign y_ext_s = {{2{bus.y_in[W-1]}}, bus.y_in};
    assign x_sh_s  = x_q >>> i_q;
    assign y_sh_s  = y_q >>> i_q;

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.mag_out   = mag_q;
    assign bus.angle_out = angle_q;

    // Next-state and datapath: capture/pre-rotate, iterate, scale, hold result
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        i_d         = i_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        mag_d       = mag_q;
        angle_d     = angle_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    zero_d  = (bus.x_in == W'(0)) && (bus.y_in == W'(0));
                    i_d     = 4'd0;
                    state_d = S_RUN;
                    // Rotate left-half-plane vectors by -/+90 deg so the
                    // iterations only ever have to cover +/-99.9 deg.
                    if (bus.x_in[W-1] == 1'b0) begin
                        x_d = x_ext_s;
                        y_d = y_ext_s;
                        z_d = W'(32'sd0);
                    end else if (bus.y_in[W-1] == 1'b0) begin
                        x_d = y_ext_s;
                        y_d = -x_ext_s;
                        z_d = ANG_P90;
                    end else begin
                        x_d = -y_ext_s;
                        y_d = x_ext_s;
                        z_d = ANG_M90;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // Drive y toward zero; y==0 counts as non-negative so (-a,0)
                // resolves to +180 deg.
                if (y_q[XW-1] == 1'b0) begin
                    x_d = x_q + y_sh_s;
                    y_d = y_q - x_sh_s;
                    z_d = z_q + atan_lut(i_q);
                end else begin
                    x_d = x_q - y_sh_s;
                    y_d = y_q + x_sh_s;
                    z_d = z_q - atan_lut(i_q);
                end
                i_d = i_q + 4'd1;
                if (i_q == ITER_LAST) begin
                    state_d = S_SCALE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_SCALE: begin
                if (zero_q) begin
                    mag_d   = W'(32'sd0);
                    angle_d = W'(32'sd0);
                end else begin
                    mag_d   = W'((PW'(x_q) * GAIN_K) >>> 8);
                    angle_d = z_q;
                end
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            i_q         <= 4'd0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            mag_q       <= '0;
            angle_q     <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            i_q         <= i_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            mag_q       <= mag_d;
            angle_q     <= angle_d;
        end
    end

endmodule

// File: tb/tb_cordic_vectoring.sv
// tb_cordic_vectoring
// Self-checking bench for cordic_vectoring: table of vectors with expected
// angle/magnitude, scoreboard queue filled on accept and drained on output
// handshake, plus hand-written reset, backpressure and abort sequences.
module tb_cordic_vectoring;

    localparam int W    = 24;
    localparam int ITER = 16;
    localparam int LAT  = ITER + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    cordic_vectoring_if #(.W(W)) bus ();

    cordic_vectoring #(.W(W), .ITER(ITER)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int    x;
        int    y;
        int    exp_ang;
        int    ang_tol;
        int    exp_mag;
        string name;
    } vec_t;

    typedef struct {
        int     exp_ang;
        int     ang_tol;
        int     exp_mag;
        longint acc_cyc;
        string  name;
    } exp_t;

    exp_t   sb_q[$];
    exp_t   cur_e;
    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;
    logic   ov_prev  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp, input longint tol);
        n_checks++;
        if (act > exp + tol || act < exp - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    task automatic check_min(input string name, input longint act, input longint lo);
        n_checks++;
        if (act < lo) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected >= %0d", name, act, lo);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst && bus.out_valid && !ov_prev) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got out_valid=1, expected no result pending");
            end else begin
                check({sb_q[0].name, "_latency"}, cyc - sb_q[0].acc_cyc, LAT, 0);
            end
        end
        if (rst && bus.out_valid && bus.out_ready && sb_q.size() > 0) begin
            cur_e = sb_q.pop_front();
            check({cur_e.name, "_angle"}, longint'(bus.angle_out), cur_e.exp_ang, cur_e.ang_tol);
            check({cur_e.name, "_mag"}, longint'(bus.mag_out), cur_e.exp_mag, cur_e.exp_mag / 200);
        end
        ov_prev <= bus.out_valid;
    end

    task automatic send(input int x, input int y, input bit push, input int ea, input int at,
                        input int em, input string name, output longint acc);
        int k = 0;
        @(posedge clk);
        #1;
        bus.x_in     = W'(x);
        bus.y_in     = W'(y);
        bus.in_valid = 1'b1;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.in_ready && k < 200);
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_accept_timeout: got in_ready=0, expected 1 within 200 cycles", name);
            bus.in_valid = 1'b0;
            acc = cyc;
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            bus.in_valid = 1'b0;
            if (push) sb_q.push_back('{exp_ang: ea, ang_tol: at, exp_mag: em, acc_cyc: acc, name: name});
        end
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (sb_q.size() > 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({name, "_pending_results"}, sb_q.size(), 0, 0);
        sb_q.delete();
    endtask

    // Watchdog: never hang
    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t   tbl[11];
        longint acc;
        longint last_acc;
        int     seen;
        logic signed [W-1:0] m0;
        logic signed [W-1:0] a0;

        tbl[0]  = '{25600,    25600,    11520, 8, 36204,   "q1_45"};
        tbl[1]  = '{0,        25600,    23040, 8, 25600,   "pos_y"};
        tbl[2]  = '{-25600,   0,        46080, 8, 25600,   "neg_x"};
        tbl[3]  = '{-25600,   -25600,  -34560, 8, 36204,   "q3_225"};
        tbl[4]  = '{0,        -25600,  -23040, 8, 25600,   "neg_y"};
        tbl[5]  = '{0,        0,        0,     0, 0,       "zero"};
        tbl[6]  = '{25600,    12800,    6801,  8, 28622,   "q1_26"};
        tbl[7]  = '{-12800,   -25600,  -29841, 8, 28622,   "q3_243"};
        tbl[8]  = '{2000000,  0,        0,     8, 2000000, "big_x"};
        tbl[9]  = '{-1000000, 1000000,  34560, 8, 1414214, "q2_big"};
        tbl[10] = '{25600,    -25600,  -11520, 8, 36204,   "q4_315"};

        bus.in_valid  = 1'b1;
        bus.x_in      = W'(25600);
        bus.y_in      = W'(25600);
        bus.out_ready = 1'b1;
        rst           = 1'b0;

        // Reset held with in_valid asserted
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_in_ready", bus.in_ready, 1, 0);
            check("rst_out_valid", bus.out_valid, 0, 0);
            check("rst_mag", longint'(bus.mag_out), 0, 0);
            check("rst_angle", longint'(bus.angle_out), 0, 0);
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_no_capture", bus.in_ready, 1, 0);

        // Table vectors back to back with out_ready tied high
        last_acc = 0;
        for (int i = 0; i < 11; i++) begin
            send(tbl[i].x, tbl[i].y, 1'b1, tbl[i].exp_ang, tbl[i].ang_tol, tbl[i].exp_mag, tbl[i].name, acc);
            if (i > 0) check_min({tbl[i].name, "_spacing"}, acc - last_acc, ITER + 2);
            last_acc = acc;
        end
        drain("table");

        // Backpressure: stall the result for 10 cycles, poke in_valid meanwhile
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(-25600, 25600, 1'b1, 34560, 8, 36204, "stall", acc);
        seen = 0;
        while (!bus.out_valid && seen < 40) begin
            @(negedge clk);
            seen++;
        end
        check("stall_out_valid_rise", bus.out_valid, 1, 0);
        m0 = bus.mag_out;
        a0 = bus.angle_out;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall_out_valid", bus.out_valid, 1, 0);
            check("stall_in_ready", bus.in_ready, 0, 0);
            check("stall_mag_hold", longint'(bus.mag_out), longint'(m0), 0);
            check("stall_angle_hold", longint'(bus.angle_out), longint'(a0), 0);
            if (c == 3) begin
                bus.x_in     = W'(25600);
                bus.y_in     = W'(0);
                bus.in_valid = 1'b1;
            end else if (c == 5) begin
                bus.in_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_out_valid", bus.out_valid, 0, 0);
        check("release_in_ready", bus.in_ready, 1, 0);
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("stall_vector_ignored", seen, 0, 0);
        drain("stall");

        // Abort: reset 5 cycles into a computation
        send(25600, 25600, 1'b0, 0, 0, 0, "abort", acc);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", bus.out_valid, 0, 0);
        check("abort_in_ready", bus.in_ready, 1, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("abort_no_result", seen, 0, 0);
        send(25600, 0, 1'b1, 0, 8, 25600, "after_abort", acc);
        drain("after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
